fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Drain-side consumer for the board's byte queue. It pops bytes from a standard (non-FWFT) FIFO read port and serialises each one as an asynchronous UART frame on tx: 1 start, DATA_BITS data LSB-first, 1 stop. It sits between the queue's read interface and the board TX pin. An LED mirrors transmit activity.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = CLK_HZ/BAUD (integer divide), DIV >= 2 is required, with an elaboration-time check
DATA_BITS, 8, data bits per frame, range 5..8

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO has no data
fifo_rd  output  1  one-cycle pop request to FIFO
fifo_data  input  DATA_BITS  FIFO read data, valid the cycle after fifo_rd
tx  output  1  serial line, idle high
busy  output  1  high from pop until end of stop bit
led  output  1  equals busy

Behaviour:
- Reset values: tx=1, fifo_rd=0, busy=0, state=IDLE, baud and bit counters=0, shift register=0.
- States: IDLE, FETCH, START, DATA, (PARITY), STOP.
- IDLE:
  - If fifo_empty=0, assert fifo_rd for exactly 1 cycle, set busy=1, go to FETCH.
  - Otherwise stay in IDLE with fifo_rd=0.
- FETCH: one cycle. Capture fifo_data into the shift register at the end of the cycle. Go to START.
- START: tx=0 for DIV cycles.
- DATA: DATA_BITS bits, LSB first, DIV cycles each. Shift right on each bit boundary.
- STOP: tx=1 for DIV cycles, then go to IDLE and clear busy.
- Latency and timing:
  - Pop in cycle c gives a start-bit falling edge at c+2.
  - Back-to-back frames have exactly 2 idle-high cycles between the end of stop and the next start bit (IDLE plus FETCH).
- The baud counter clears on every state entry. A bit boundary occurs when the count reaches DIV-1.
- fifo_empty is sampled only in IDLE. fifo_rd is never asserted while fifo_empty=1 or outside IDLE.
- tx is driven from a register, so it is glitch-free.
- Reset mid-frame:
  - On the next edge, tx=1 and the state returns to IDLE.
  - The popped byte is discarded and not re-popped.
  - No fifo_rd is issued while rst=1.
- A FIFO that goes empty during a frame has no effect on the current frame.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of the data bits) for DIV cycles. The frame becomes DATA_BITS+3 bits.
- Undefined: the PARITY state and its logic are absent. The frame is DATA_BITS+2 bits.

Decomposition:
- Package uart_pkg:
  - state enum type
  - function computing DIV from CLK_HZ/BAUD
  - TX_IDLE_LEVEL=1 constant
- Sub-module uart_baud_cnt:
  - parameter DIV
  - inputs clk, rst, clr; output tick (1 when count==DIV-1, then count wraps to 0)
  - counter width $clog2(DIV)
- The top level instantiates uart_baud_cnt once and holds the FSM, shift register and bit counter.

Test Plan:
All scenarios use CLK_HZ=1000000, BAUD=100000, so DIV=10.
- Reset: rst=1 for 5 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_rd=0 throughout. The first fifo_rd occurs in the first cycle after rst falls.
- Single byte 0xA5 -> fifo_rd high 1 cycle at c; tx=0 during c+2..c+11; data bits 1,0,1,0,0,1,0,1 each 10 cycles; stop high 10 cycles; busy low at c+102.
- Back-to-back 0x00 then 0xFF -> exactly 2 pops; 2 high cycles between the first stop end and the second start; tx low for 90 cycles in frame 1 and high for 90 cycles (data+stop) in frame 2.
- Reset asserted during data bit 3 of 0x55 -> tx=1 on the next cycle, busy=0, no fifo_rd while rst=1, no residual bits after release.
- fifo_empty=1 for 500 cycles -> fifo_rd never asserted, tx=1, busy=0.
- UART_TX_PARITY_EN defined -> 0x07 gives parity bit 1 and 0x03 gives parity bit 0; each frame is 110 cycles, and the stop bit follows the parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter.
//   uart_state_t  : transmitter FSM states (PARITY exists only when
//                   UART_TX_PARITY_EN is defined)
//   calc_div      : clock cycles per UART bit, CLK_HZ / BAUD (integer divide)
//   TX_IDLE_LEVEL : level of the serial line between frames
// Optional feature macro: UART_TX_PARITY_EN
package uart_pkg;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd5
`endif
  } uart_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter for the UART transmitter.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear, holds the count at zero
//   tick : high while the count equals DIV-1; the count wraps to 0 next cycle
module uart_baud_cnt #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a standard (non-FWFT) FIFO read port and sends each one
// as a UART frame: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// With UART_TX_PARITY_EN defined an even-parity bit sits between the data
// and the stop bit.
//   clk        : system clock, posedge
//   rst        : synchronous active-high reset
//   fifo_empty : FIFO has no data (looked at only in IDLE)
//   fifo_rd    : one-cycle pop request
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd
//   tx         : serial line, idle high, registered
//   busy       : high from the cycle after the pop until the end of stop
//   led        : copy of busy
//   state      : current FSM state, for observation
// Handshake: a byte is taken when fifo_rd is high at a rising clk edge;
// the FIFO presents it on fifo_data during the following cycle, which is
// the single FETCH cycle in which it is captured.
// Optional feature macro: UART_TX_PARITY_EN
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 led,
  output uart_state_t          state
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("fifo_uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
    $error("fifo_uart_tx: DATA_BITS must be in 5..8");
  end

  logic                 tick;
  logic                 clr;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  // Timed states are always left on a tick, where the counter wraps to 0
  // by itself, so holding it clear in the untimed states is enough for
  // every timed state to start from a zero count.
  assign clr = (state == ST_IDLE) || (state == ST_FETCH);

  uart_baud_cnt #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // The pop is decoded from the registered state so that the byte arrives
  // in FETCH and the start bit begins two cycles after the pop.
  assign fifo_rd = (state == ST_IDLE) && !fifo_empty && !rst;
  assign led     = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= TX_IDLE_LEVEL;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          shreg <= fifo_data;
`ifdef UART_TX_PARITY_EN
          parity <= ^fifo_data;
`endif
          tx    <= ~TX_IDLE_LEVEL;
          state <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= ST_PARITY;
`else
              tx    <= TX_IDLE_LEVEL;
              state <= ST_STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx    <= TX_IDLE_LEVEL;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          tx    <= TX_IDLE_LEVEL;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
